// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO byte offsets, status bit
// positions and the address-region type produced by the top-level decode.
package dmem_pkg;

  localparam logic [4:0] OFF_LED     = 5'h00;
  localparam logic [4:0] OFF_CYCLE   = 5'h04;
  localparam logic [4:0] OFF_TXDATA  = 5'h08;
  localparam logic [4:0] OFF_TXLVL   = 5'h0C;
  localparam logic [4:0] OFF_ERRADDR = 5'h10;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_ERR   = 3;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_NONE
  } region_e;

endpackage

// File: rtl/dmem_tx_fifo.sv
// Synchronous byte FIFO for the TX path. A push while full succeeds only when a pop
// happens in the same cycle; the head is registered, so there is no fall-through.
module dmem_tx_fifo #(
  parameter int LOG2 = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [7:0]      wdata_i,
  output logic [7:0]      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [LOG2:0]   level_o
);

  localparam int            DEPTH   = 2**LOG2;
  localparam logic [LOG2:0] DEPTH_L = (LOG2+1)'(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LOG2:0]   lvl_q, lvl_d;
  logic            do_push, do_pop;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == DEPTH_L);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      lvl_d = lvl_q + 1'b1;
    else if (!do_push && do_pop) lvl_d = lvl_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word RAM with byte lanes, LED/cycle/TX-FIFO MMIO page.
// Optional DMEM_ERR_TRAP_EN adds a sticky unmapped-access trap with ERR_ADDR at MMIO 0x10.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          TXF_LOG2   = 3,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  mem_write_en,
  input  logic        mem_read_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  led
);

  localparam int RAM_WORDS = 2**DEPTH_LOG2;

  logic [31:0]           ram_q [RAM_WORDS];
  logic [DEPTH_LOG2-1:0] ram_idx;
  region_e               region;
  logic [4:0]            off;
  logic                  wr_any, rd_req, mmio_wr, push, pop, full, empty;
  logic [TXF_LOG2:0]     level;
  logic [31:0]           rd_val, status, err_addr_rd;
  logic                  err_bit;
  logic [31:0]           rdata_q, rdata_d, cycle_q, cycle_d;
  logic [7:0]            led_q, led_d;
  logic                  ovf_q, ovf_d;
  logic                  unused_addr_lsbs;

  assign ram_idx          = mem_addr[DEPTH_LOG2+1:2];
  assign off              = {mem_addr[4:2], 2'b00};
  assign unused_addr_lsbs = ^mem_addr[1:0];

  always_comb begin
    region = RGN_NONE;
    if (mem_addr[31:DEPTH_LOG2+2] == '0)         region = RGN_RAM;
    else if (mem_addr[31:5] == MMIO_BASE[31:5]) region = RGN_MMIO;
  end

  assign wr_any   = en & (|mem_write_en);
  assign rd_req   = en & mem_read_en;
  assign mmio_wr  = wr_any & (region == RGN_MMIO);
  assign push     = mmio_wr & (off == OFF_TXDATA);
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~empty;
  assign status   = {28'd0, err_bit, ovf_q, full, empty};

  dmem_tx_fifo #(.LOG2(TXF_LOG2)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (mem_write_data[7:0]),
    .rdata_o (tx_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Lane i drives bits 8i+7:8i, i.e. byte address 3-i (big-endian).
  always_ff @(posedge clk) begin
    if (en && region == RGN_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_en[i]) ram_q[ram_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (region == RGN_RAM) begin
      rd_val = ram_q[ram_idx];
    end else if (region == RGN_MMIO) begin
      case (off)
        OFF_LED:     rd_val = {24'd0, led_q};
        OFF_CYCLE:   rd_val = cycle_q;
        OFF_TXDATA:  rd_val = status;
        OFF_TXLVL:   rd_val = 32'(level);
        OFF_ERRADDR: rd_val = err_addr_rd;
        default:     rd_val = '0;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    cycle_d = cycle_q;
    led_d   = led_q;
    ovf_d   = ovf_q;
    if (en)     cycle_d = cycle_q + 32'd1;
    if (rd_req) rdata_d = rd_val;
    if (mmio_wr && off == OFF_LED)   led_d = mem_write_data[7:0];
    if (mmio_wr && off == OFF_TXLVL) ovf_d = 1'b0;
    if (push && full && !pop)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      cycle_q <= '0;
      led_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      cycle_q <= cycle_d;
      led_q   <= led_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DMEM_ERR_TRAP_EN
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  // Only the first fault is kept until software clears it through ERR_ADDR.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (mmio_wr && off == OFF_ERRADDR) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (!err_q && en && (mem_read_en || (|mem_write_en)) && region == RGN_NONE) begin
      err_d      = 1'b1;
      err_addr_d = mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_bit     = err_q;
  assign err_addr_rd = err_addr_q;
`else
  assign err_bit     = 1'b0;
  assign err_addr_rd = '0;
`endif

  assign mem_read_data = rdata_q;
  assign led           = led_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed spec scenarios followed by random
// traffic, predicted by a transaction-level model of the memory map.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int          FIFO_DEPTH = 8;
  localparam bit [31:0]   MM         = 32'hFFFF_0000;
`ifdef DMEM_ERR_TRAP_EN
  localparam bit          TRAP       = 1'b1;
`else
  localparam bit          TRAP       = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, mem_read_en, tx_ready;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [7:0]  tx_data, led;
  logic        tx_valid;

  int checks = 0;
  int errors = 0;

  data_mem_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .led            (led)
  );

  always #5 clk = ~clk;

  // reference model state (valid after the most recent rising edge)
  bit [31:0]    m_ram [int];
  bit [7:0]     m_led;
  bit [31:0]    m_cyc;
  byte unsigned m_fifo [$];
  bit           m_ovf, m_err;
  bit [31:0]    m_erra;

  bit [31:0]    exp_rd [$];
  byte unsigned exp_tx [$];

  bit           mon_rd_seen  = 1'b0;
  bit           mon_rst_seen = 1'b1;
  bit [31:0]    mon_last     = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // 0 = RAM (first 4 KiB), 1 = MMIO page, 2 = unmapped
  function automatic int region(input bit [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if ((a & 32'hFFFF_FFE0) == MM) return 1;
    return 2;
  endfunction

  function automatic bit [31:0] model_read(input bit [31:0] a);
    bit [31:0] st;
    st = {28'd0, TRAP & m_err, m_ovf, m_fifo.size() == FIFO_DEPTH, m_fifo.size() == 0};
    case (region(a))
      0: return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'd0;
      1: case (a & 32'h1C)
           32'h00:  return {24'd0, m_led};
           32'h04:  return m_cyc;
           32'h08:  return st;
           32'h0C:  return 32'(m_fifo.size());
           32'h10:  return TRAP ? m_erra : 32'd0;
           default: return 32'd0;
         endcase
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit        pop, push_req;
    bit [31:0] w;
    int        r;
    if (!rst_n) begin
      m_led = 0; m_cyc = 0; m_ovf = 0; m_err = 0; m_erra = 0;
      m_fifo.delete();
      exp_tx.delete();
      return;
    end
    pop      = tx_ready && m_fifo.size() > 0;
    push_req = 1'b0;
    r        = region(mem_addr);
    if (en && mem_read_en) exp_rd.push_back(model_read(mem_addr));
    if (en) begin
      if (mem_write_en != 0) begin
        if (r == 0) begin
          w = m_ram.exists(int'(mem_addr >> 2)) ? m_ram[int'(mem_addr >> 2)] : 32'd0;
          for (int i = 0; i < 4; i++)
            if (mem_write_en[i]) w[8*i +: 8] = mem_write_data[8*i +: 8];
          m_ram[int'(mem_addr >> 2)] = w;
        end else if (r == 1) begin
          case (mem_addr & 32'h1C)
            32'h00: m_led = mem_write_data[7:0];
            32'h08: push_req = 1'b1;
            32'h0C: m_ovf = 1'b0;
            32'h10: begin m_err = 1'b0; m_erra = 32'd0; end
            default: ;
          endcase
        end
      end
      if (TRAP && r == 2 && (mem_read_en || mem_write_en != 0) && !m_err) begin
        m_err  = 1'b1;
        m_erra = mem_addr;
      end
      m_cyc = m_cyc + 32'd1;
    end
    if (pop) void'(m_fifo.pop_front());
    if (push_req) begin
      if (m_fifo.size() < FIFO_DEPTH) begin
        m_fifo.push_back(mem_write_data[7:0]);
        exp_tx.push_back(mem_write_data[7:0]);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic op(input bit e, input bit [3:0] we, input bit rd, input bit [31:0] a, input bit [31:0] d);
    en = e; mem_write_en = we; mem_read_en = rd; mem_addr = a; mem_write_data = d;
    tick();
  endtask

  task automatic idle();
    op(1'b1, 4'h0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic bit [31:0] rand_ram_addr();
    int w;
    w = $urandom_range(0, 19);
    if (w >= 16) w = w + 1004;
    return 32'(w * 4 + $urandom_range(0, 3));
  endfunction

  function automatic bit [3:0] rand_we();
    case ($urandom_range(0, 3))
      0: return 4'hF;
      1: return 4'b1100;
      2: return 4'b0011;
      default: return 4'(1 << $urandom_range(0, 3));
    endcase
  endfunction

  task automatic random_op();
    int        k;
    bit        e;
    bit [31:0] a;
    k        = $urandom_range(0, 99);
    e        = ($urandom_range(0, 9) != 0);
    tx_ready = ($urandom_range(0, 3) == 0);
    if (k < 30)      op(e, 4'h0, 1'b1, rand_ram_addr(), 32'd0);
    else if (k < 50) op(e, rand_we(), 1'b0, rand_ram_addr(), $urandom);
    else if (k < 55) op(e, rand_we(), 1'b1, rand_ram_addr(), $urandom);
    else if (k < 75) op(e, 4'h0, 1'b1, MM + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)), 32'd0);
    else if (k < 90) begin
      case ($urandom_range(0, 5))
        0:       a = MM;
        4:       a = MM + 32'h0C;
        5:       a = MM + 32'h10;
        default: a = MM + 32'h08;
      endcase
      op(e, rand_we(), 1'b0, a, $urandom);
    end else begin
      a = 32'h4000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
      if ($urandom_range(0, 1) == 0) op(e, 4'h0, 1'b1, a, 32'd0);
      else                           op(e, rand_we(), 1'b0, a, $urandom);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin : monitor
    bit [31:0] exp;
    forever begin
      @(negedge clk);
      if (mon_rd_seen) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_queue: read returned %h with no expectation", mem_read_data);
          exp = mon_last;
        end else begin
          exp = exp_rd.pop_front();
        end
      end else if (mon_rst_seen) begin
        exp = 32'd0;
      end else begin
        exp = mon_last;
      end
      check("mem_read_data", mem_read_data, exp);
      mon_last = exp;
      check("led", {24'd0, led}, {24'd0, m_led});
      check("tx_valid", {31'd0, tx_valid}, {31'd0, m_fifo.size() != 0});
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_queue: byte %h emitted with none expected", tx_data);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        end
      end
      mon_rd_seen  = en && mem_read_en && rst_n;
      mon_rst_seen = !rst_n;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_n = 1'b0; en = 1'b0; mem_write_en = 4'h0; mem_read_en = 1'b0;
    mem_addr = '0; mem_write_data = '0; tx_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++)      op(1'b1, 4'hF, 1'b0, 32'(w * 4), $urandom);
    for (int w = 1020; w < 1024; w++) op(1'b1, 4'hF, 1'b0, 32'(w * 4), $urandom);

    // byte lane merge: expect 0xDE55BEEF
    op(1'b1, 4'hF, 1'b0, 32'h10, 32'hDEAD_BEEF);
    op(1'b1, 4'b0100, 1'b0, 32'h11, 32'h5555_5555);
    op(1'b1, 4'h0, 1'b1, 32'h10, 32'd0);
    // read-first on same word
    op(1'b1, 4'hF, 1'b1, 32'h14, 32'h1234_5678);
    op(1'b1, 4'h0, 1'b1, 32'h14, 32'd0);

    op(1'b1, 4'b0001, 1'b0, MM, 32'hA3A3_A3A3);
    op(1'b1, 4'h0, 1'b1, MM, 32'd0);
    op(1'b1, 4'hF, 1'b0, MM, 32'h0000_015C);
    op(1'b1, 4'h0, 1'b1, MM + 32'h3, 32'd0);

    op(1'b1, 4'h0, 1'b1, MM + 32'h04, 32'd0);
    repeat (4) idle();
    op(1'b1, 4'h0, 1'b1, MM + 32'h04, 32'd0);
    op(1'b0, 4'hF, 1'b0, 32'h10, 32'd0);
    op(1'b0, 4'hF, 1'b0, MM, 32'hFF);
    op(1'b0, 4'h0, 1'b1, MM + 32'h04, 32'd0);
    op(1'b1, 4'h0, 1'b1, 32'h10, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h04, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM, 32'd0);

    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) op(1'b1, 4'b0001, 1'b0, MM + 32'h08, {4{8'(8'h10 + i)}});
    op(1'b1, 4'h0, 1'b1, MM + 32'h0C, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h08, 32'd0);
    op(1'b1, 4'hF, 1'b0, MM + 32'h0C, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h08, 32'd0);
    tx_ready = 1'b1;
    op(1'b1, 4'hF, 1'b0, MM + 32'h08, 32'h0000_00A5);
    tx_ready = 1'b0;
    op(1'b1, 4'h0, 1'b1, MM + 32'h0C, 32'd0);
    tx_ready = 1'b1;
    repeat (10) idle();
    tx_ready = 1'b0;

    op(1'b1, 4'b0001, 1'b0, MM, 32'h77);
    for (int i = 0; i < 3; i++) op(1'b1, 4'b0001, 1'b0, MM + 32'h08, 32'(i + 1));
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    op(1'b1, 4'h0, 1'b1, MM + 32'h0C, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h04, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM, 32'd0);

    op(1'b1, 4'h0, 1'b1, 32'h8000_0000, 32'd0);
    op(1'b1, 4'h0, 1'b1, 32'h9000_0000, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h10, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h08, 32'd0);
    op(1'b1, 4'hF, 1'b0, MM + 32'h10, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h10, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h08, 32'd0);

    repeat (600) random_op();

    tx_ready = 1'b1;
    repeat (12) op(1'b0, 4'h0, 1'b0, 32'd0, 32'd0);
    op(1'b1, 4'h0, 1'b1, MM + 32'h0C, 32'd0);
    idle();
    @(negedge clk);
    check("exp_rd_left", 32'(exp_rd.size()), 32'd0);
    check("exp_tx_left", 32'(exp_tx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
